// File: rtl/lc3_pkg.sv
// lc3_pkg: shared types and constants for the LC-3 memory-access sequencer.
//   memctrl_state_t  - sequencer FSM states
//   MMIO_BASE etc.   - device-register address map (KBSR/KBDR/DSR/DDR/MCR)
//   COND_MEM_READY   - microsequencer COND code that waits on R
package lc3_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} memctrl_state_t;

    localparam logic [ADDR_W-1:0] MMIO_BASE = 16'hFE00;
    localparam logic [ADDR_W-1:0] KBSR      = 16'hFE00;
    localparam logic [ADDR_W-1:0] KBDR      = 16'hFE02;
    localparam logic [ADDR_W-1:0] DSR       = 16'hFE04;
    localparam logic [ADDR_W-1:0] DDR       = 16'hFE06;
    localparam logic [ADDR_W-1:0] MCR       = 16'hFFFE;

    localparam logic [2:0] COND_MEM_READY = 3'b001;

    function automatic logic is_mmio(input logic [ADDR_W-1:0] addr);
        return addr >= MMIO_BASE;
    endfunction
endpackage

// File: rtl/lc3_timeout_ctr.sv
// lc3_timeout_ctr: saturating wait counter with an expire flag at TIMEOUT-1.
//   clk, rst_n  - clock, synchronous active-low reset
//   clr_i       - restart the count at zero (has priority over en_i)
//   en_i        - count one cycle
//   expire_o    - count has reached TIMEOUT-1
module lc3_timeout_ctr #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire_o = cnt_q == CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: LC-3 memory-access sequencer (MIO.EN -> req/ack -> R pulse).
//   clk, rst_n              - clock, synchronous active-low reset
//   mio_en, r_w, mar, mdr_out - access request from control store / datapath
//   R, rdata, bus_err       - ready pulse, read data, sticky timeout flag
//   mem_req/we/addr/wdata   - registered request to memory
//   mem_rdata, mem_ack      - memory response
//   io_req, io_ack, io_rdata - device-register port, present only when
//                              LC3_MEMCTRL_MMIO_EN is defined
module lc3_mem_ctrl
    import lc3_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mio_en,
    input  logic              r_w,
    input  logic [ADDR_W-1:0] mar,
    input  logic [DATA_W-1:0] mdr_out,
    output logic              R,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef LC3_MEMCTRL_MMIO_EN
    ,
    output logic              io_req,
    input  logic              io_ack,
    input  logic [DATA_W-1:0] io_rdata
`endif
);
    memctrl_state_t    state_q;
    logic              r_q, bus_err_q, mem_req_q, mem_we_q;
    logic [DATA_W-1:0] rdata_q, wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              start, ack, expire;
    logic [DATA_W-1:0] resp_data;

`ifdef LC3_MEMCTRL_MMIO_EN
    logic io_req_q;
    assign ack       = io_req_q ? io_ack : mem_ack;
    assign resp_data = io_req_q ? io_rdata : mem_rdata;
    assign io_req    = io_req_q;
`else
    assign ack       = mem_ack;
    assign resp_data = mem_rdata;
`endif

    // The microsequencer still holds MIO.EN in its wait state while R is high,
    // so the R cycle must not launch a new access.
    assign start = state_q == IDLE && mio_en && !r_q;

    lc3_timeout_ctr #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (start),
        .en_i    (state_q == BUSY),
        .expire_o(expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            r_q       <= 1'b0;
            bus_err_q <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            rdata_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
`ifdef LC3_MEMCTRL_MMIO_EN
            io_req_q  <= 1'b0;
`endif
        end else begin
            r_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    addr_q    <= mar;
                    mem_we_q  <= r_w;
                    wdata_q   <= mdr_out;
                    bus_err_q <= 1'b0;
`ifdef LC3_MEMCTRL_MMIO_EN
                    mem_req_q <= !is_mmio(mar);
                    io_req_q  <= is_mmio(mar);
`else
                    mem_req_q <= 1'b1;
`endif
                    state_q   <= BUSY;
                end
                BUSY: if (ack || expire) begin
                    // ack takes priority over a coincident timeout
                    if (ack && !mem_we_q) rdata_q <= resp_data;
                    if (!ack) begin
                        bus_err_q <= 1'b1;
                        rdata_q   <= '0;
                    end
                    mem_req_q <= 1'b0;
`ifdef LC3_MEMCTRL_MMIO_EN
                    io_req_q  <= 1'b0;
`endif
                    state_q   <= DONE;
                end
                DONE: begin
                    r_q     <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign R         = r_q;
    assign rdata     = rdata_q;
    assign bus_err   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: self-checking bench for lc3_mem_ctrl (vector table + random accesses).
module tb_lc3_mem_ctrl;
    localparam int TO = 8;

    logic        clk = 0, rst_n = 0, mio_en = 0, r_w = 0, mem_ack = 0;
    logic [15:0] mar = 0, mdr_out = 0, mem_rdata = 0;
    logic        R, bus_err, mem_req, mem_we;
    logic [15:0] rdata, mem_addr, mem_wdata;
`ifdef LC3_MEMCTRL_MMIO_EN
    logic        io_req, io_ack = 0;
    logic [15:0] io_rdata = 0;
`endif

    int checks = 0, errors = 0;
    logic [15:0] exp_rdata = 0;

    lc3_mem_ctrl #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .mio_en(mio_en), .r_w(r_w), .mar(mar), .mdr_out(mdr_out),
        .R(R), .rdata(rdata), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef LC3_MEMCTRL_MMIO_EN
        , .io_req(io_req), .io_ack(io_ack), .io_rdata(io_rdata)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One access, driven from a negedge. dly = BUSY cycles before ack; dly >= TO means no ack.
    // Expected timing derived from: request visible after edge 0, ack sampled at edge dly+1,
    // R visible one cycle after the completion edge; a timeout completes on edge TO.
    task automatic do_access(input logic [15:0] a, input logic we, input logic [15:0] wd,
                             input int dly, input logic [15:0] rd, input bit hold);
        bit ack_ok = dly < TO;
        int exp_edge = ack_ok ? dly + 2 : TO + 1;
        int exp_reqs = ack_ok ? dly + 1 : TO;
        int r_edge = -1, reqs = 0;
        mio_en = 1; mar = a; r_w = we; mdr_out = wd;
        for (int e = 0; e < TO + 6 && r_edge < 0; e++) begin
            cyc();
            mar = 16'($urandom); r_w = 1'($urandom); mdr_out = 16'($urandom);
            if (e == 0) begin
                check("req_rise", mem_req, 1);
                check("bus_err_clr", bus_err, 0);
            end
            if (mem_req) begin
                reqs++;
                check("addr_stable", mem_addr, a);
                check("we_stable", mem_we, we);
                check("wdata_stable", mem_wdata, wd);
            end
            mem_ack = ack_ok && e == dly;
            mem_rdata = mem_ack ? rd : 16'($urandom);
            if (R) r_edge = e;
        end
        mem_ack = 0;
        if (ack_ok && !we) exp_rdata = rd;
        else if (!ack_ok) exp_rdata = 16'h0000;
        check("r_latency", r_edge, exp_edge);
        check("req_cycles", reqs, exp_reqs);
        check("rdata", rdata, exp_rdata);
        check("bus_err", bus_err, !ack_ok);
        cyc();
        check("r_single", R, 0);
        check("idle_gap", mem_req, 0);
        if (!hold) mio_en = 0;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        int          dly;
        logic [15:0] rd;
        bit          hold;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'h3000, 1'b0, 16'h0000, 0,      16'h1234, 1'b0};
        vecs[1] = '{16'h4000, 1'b1, 16'hBEEF, 5,      16'h5555, 1'b0};
        vecs[2] = '{16'h3002, 1'b0, 16'h0000, TO,     16'h7777, 1'b0};
        vecs[3] = '{16'h3004, 1'b0, 16'h0000, 1,      16'hA5A5, 1'b0};
        vecs[4] = '{16'h3006, 1'b0, 16'h0000, TO - 1, 16'hC3C3, 1'b0};
        vecs[5] = '{16'h5000, 1'b1, 16'h1111, TO,     16'h9999, 1'b0};
        vecs[6] = '{16'h6000, 1'b0, 16'h0000, 2,      16'h2468, 1'b1};
        vecs[7] = '{16'h6001, 1'b1, 16'hCAFE, 0,      16'h0F0F, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_R", R, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst_n = 1;
        mem_ack = 1;
        repeat (3) begin
            cyc();
            check("idle_ack_R", R, 0);
            check("idle_ack_req", mem_req, 0);
        end
        mem_ack = 0;

        foreach (vecs[i]) begin
            do_access(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].dly, vecs[i].rd, vecs[i].hold);
            if (!vecs[i].hold) cyc();
        end

        // reset in the middle of a BUSY period, followed by a stray ack
        mio_en = 1; mar = 16'h5555; r_w = 0;
        cyc();
        mio_en = 0;
        cyc();
        rst_n = 0;
        cyc();
        check("midrst_req", mem_req, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_rdata", rdata, 0);
        check("midrst_R", R, 0);
        rst_n = 1;
        exp_rdata = 0;
        mem_ack = 1; mem_rdata = 16'hABCD;
        repeat (4) begin
            cyc();
            check("late_ack_R", R, 0);
            check("late_ack_req", mem_req, 0);
            check("late_ack_rdata", rdata, 0);
        end
        mem_ack = 0;

        for (int i = 0; i < 24; i++) begin
            bit h = 1'($urandom);
            do_access(16'($urandom) & 16'h7FFF, 1'($urandom), 16'($urandom),
                      int'($urandom_range(0, TO + 2)), 16'($urandom), h);
            if (!h) repeat ($urandom_range(0, 3)) cyc();
        end
        mio_en = 0;
        cyc();

`ifdef LC3_MEMCTRL_MMIO_EN
        mio_en = 1; mar = 16'hFE04; r_w = 0;
        cyc();
        mio_en = 0;
        check("io_req", io_req, 1);
        check("io_mem_req", mem_req, 0);
        io_ack = 1; io_rdata = 16'h8000; mem_ack = 1; mem_rdata = 16'h1111;
        cyc();
        io_ack = 0; mem_ack = 0;
        check("io_req_drop", io_req, 0);
        cyc();
        check("io_R", R, 1);
        check("io_rdata", rdata, 16'h8000);
        check("io_bus_err", bus_err, 0);
        cyc();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
